// File: rtl/sample_pingpong_buffer_pkg.sv
// Shared types for the ping-pong sample buffer: sample width, sample type and reader states.
package sample_pingpong_buffer_pkg;

   localparam int DEFAULT_DATA_W = 24;
   localparam int DROP_CNT_W     = 16;

   typedef logic signed [DEFAULT_DATA_W-1:0] sample_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_ANNOUNCE,
      R_STREAM
   } rd_state_e;

endpackage

// File: rtl/sample_pingpong_buffer_dpram.sv
// sample_dpram: simple dual-port RAM holding both banks; one write port, registered read port.
module sample_dpram #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 5
) (
   input  logic              clk_i,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // NOTE: the array and read register carry no reset; a reset would block
   // block-RAM inference, and stale contents are never presented as valid.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/sample_pingpong_buffer.sv
// sample_pingpong_buffer: fills one bank while the other streams to the VU meter.
// Define SAMPLE_BUFFER_DROP_CNT_EN to add the saturating dropped-sample counter.
module sample_pingpong_buffer
   import sample_pingpong_buffer_pkg::*;
#(
   parameter int BUFFER_DEPTH = 16,
   parameter int DATA_W       = DEFAULT_DATA_W
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_W-1:0]     in_data_i,
   input  logic                  in_valid_i,
   output logic [DATA_W-1:0]     rd_data_o,
   output logic                  rd_valid_o,
   input  logic                  rd_ready_i,
   output logic                  buffer_ready_o,
   output logic                  overrun_o,
   output logic [DROP_CNT_W-1:0] drop_count_o
);

   localparam int               PTR_W    = $clog2(BUFFER_DEPTH);
   localparam int               ADDR_W   = PTR_W + 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUFFER_DEPTH - 1);

   rd_state_e         state, state_nxt;
   logic              wr_bank, rd_bank, pending, overrun_q;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
   logic [DATA_W-1:0] ram_q;
   logic              wr_en, drop, bank_full, rd_fire, rd_last, reader_free, swap;

   assign wr_en       = in_valid_i && !pending;
   assign drop        = in_valid_i && pending;
   assign bank_full   = wr_en && (wr_ptr == LAST_PTR);
   assign rd_fire     = (state == R_STREAM) && rd_ready_i;
   assign rd_last     = rd_fire && (rd_ptr == LAST_PTR);
   assign reader_free = (state == R_IDLE) || rd_last;
   assign swap        = (bank_full || pending) && reader_free;

   // NOTE: sequential state uses non-blocking assignments so every register
   // updates from the values present before the clock edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= R_IDLE;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         pending   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         rd_ptr <= rd_ptr_nxt;
         if (swap) begin
            rd_bank <= wr_bank;
            wr_bank <= ~wr_bank;
            wr_ptr  <= '0;
            pending <= 1'b0;
         end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (bank_full) pending <= 1'b1;
         end
         if (drop) overrun_q <= 1'b1;
      end
   end

   // NOTE: defaults are assigned first so no path leaves a signal unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_nxt  = state;
      rd_ptr_nxt = rd_ptr;
      unique case (state)
         R_IDLE: begin
            if (swap) state_nxt = R_ANNOUNCE;
         end
         R_ANNOUNCE: begin
            state_nxt  = R_STREAM;
            rd_ptr_nxt = '0;
         end
         R_STREAM: begin
            if (rd_fire) begin
               if (rd_last) state_nxt = swap ? R_ANNOUNCE : R_IDLE;
               else         rd_ptr_nxt = rd_ptr + 1'b1;
            end
         end
         default: state_nxt = R_IDLE;
      endcase
   end

   // Read address follows the next pointer so ram_q lines up with rd_ptr one cycle later.
   sample_dpram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (clk_i),
      .wr_en   (wr_en),
      .wr_addr ({wr_bank, wr_ptr}),
      .wr_data (in_data_i),
      .rd_addr ({rd_bank, rd_ptr_nxt}),
      .rd_data (ram_q)
   );

   assign buffer_ready_o = (state == R_ANNOUNCE);
   assign rd_valid_o     = (state == R_STREAM);
   assign rd_data_o      = rd_valid_o ? ram_q : '0;
   assign overrun_o      = overrun_q;

`ifdef SAMPLE_BUFFER_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

   assign drop_count_o = drop_cnt;
`else
   assign drop_count_o = '0;
`endif

endmodule
